sram_req_sequencer: RTL and testbench
=====================================

// Module: sram_req_sequencer
// PURPOSE
//  Upstream command stage for sram_core. Accepts read/write requests on a valid/ready port and buffers them in a small FIFO.
//  Issues each request to the core's enable/read_not_write/addr/data_in pins and holds it until the core asserts ready.
//  Returns read data, with an error flag on timeout, on a valid/ready response port.
//  Decouples pin-level or host logic from the core's multi-cycle handshake.
// PARAMETERS
//  FIFO_DEPTH      4    request queue entries; power of 2, >=2
//  TIMEOUT_CYCLES  15   max cycles in WAIT before abort; >=3
//  WRITE_ACK       1    1: writes also produce a response beat; 0: writes complete silently
// PORTS
//  clk             in   1   single clock; all logic on posedge
//  rst             in   1   asynchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   request accepted when valid&ready at posedge
//  req_rnw         in   1   1=read, 0=write
//  req_addr        in   10  word address (row=[9:4], col=[3:0])
//  req_wdata       in   4   write data (ignored for reads)
//  rsp_valid       out  1   response beat present
//  rsp_ready       in   1   consumer accepts beat
//  rsp_rdata       out  4   read data; 0 for writes or errors
//  rsp_err         out  1   1 = core timed out
//  core_enable     out  1   to sram_core.enable
//  core_rnw        out  1   to sram_core.read_not_write
//  core_addr       out  10  to sram_core.addr
//  core_wdata      out  4   to sram_core.data_in
//  core_rdata      in   4   from sram_core.data_out
//  core_ready      in   1   from sram_core.ready
//  busy            out  1   FIFO non-empty or FSM != IDLE
// BEHAVIOUR
//  Reset: FIFO flushed; FSM=IDLE; timer=0.
//   Reset values: core_enable/core_rnw/core_addr/core_wdata=0, rsp_valid/rsp_rdata/rsp_err=0, busy=0, req_ready=0.
//   Reset mid-operation aborts immediately: core_enable falls asynchronously and the in-flight request is lost.
//  req_ready = !rst && !fifo_full (combinational). A push at full is not accepted.
//  Pop and push in the same cycle at full: the push is still refused; the freed slot shows on req_ready next cycle.
//  FIFO has no fall-through: an entry pushed at edge N is first visible to the FSM in cycle N+1.
//  FSM (core_* outputs are registered from the popped command register):
//   IDLE: if FIFO non-empty, pop into the command register -> ISSUE.
//   ISSUE: core_enable=1; timer cleared -> WAIT.
//   WAIT: hold core_enable and the command; timer increments each cycle.
//    If core_ready=1: capture core_rdata (reads) or 0 (writes); err=0; core_enable=0 at next edge.
//     Then go to RESP, except a write with WRITE_ACK=0 returns to IDLE.
//    Else if timer == TIMEOUT_CYCLES-1: core_enable=0, rdata=0, err=1 -> RESP (timeout always responds, even for writes).
//    core_ready and timeout in the same cycle: core_ready wins.
//   RESP: rsp_valid=1; rsp_rdata and rsp_err stable until rsp_valid & rsp_ready -> IDLE. Backpressure is unbounded.
//  core_enable is low for >=1 cycle between consecutive operations, since IDLE always intervenes.
//  Minimum latency: request accepted at edge 0; core_enable high from edge 2; core_ready seen in cycle k;
//   rsp_valid high from edge k+1.
//  Timer width $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB full/empty compare.
//  core_rdata is ignored outside the capture cycle.
// STRUCTURE
//  sram_pkg (shared):
//   SRAM_ADDR_W=10, SRAM_DATA_W=4.
//   typedef sram_req_t {rnw, addr, wdata} (15 bits packed).
//   FSM state encoding IDLE/ISSUE/WAIT/RESP (2 bits).
//  Sub-module sram_req_fifo: synchronous FIFO (DEPTH, WIDTH), push/pop/full/empty, async active-high rst.
//  Top: FSM, timer, command register, response register.
// TESTING
//  1 Reset release: rst 1->0 with req_valid=1 held.
//    -> req_ready=0 during reset and 1 the cycle after; all outputs 0 during reset.
//  2 Write then read: write addr=0x3A5, data=0xB; then read addr=0x3A5.
//    Core model raises ready 2 cycles after enable -> read rsp_rdata=0xB, err=0; write beat has rdata=0.
//  3 FIFO full: push 5 requests with the core stalled (ready=0), FIFO_DEPTH=4.
//    -> 4 accepted, req_ready=0 on the 5th; busy=1.
//  4 Timeout: core_ready held 0.
//    -> core_enable drops after TIMEOUT_CYCLES; rsp_err=1, rsp_rdata=0; next queued request then issues normally.
//  5 Backpressure: hold rsp_ready=0 for 10 cycles after a read.
//    -> rsp_valid stays 1 with stable data; no new core_enable until the beat is accepted.
//  6 Reset mid-WAIT: assert rst while core_enable=1.
//    -> core_enable=0 asynchronously; FIFO empty and busy=0 after release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the SRAM request path: command word layout and sequencer state encoding.
package sram_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 4;

  typedef struct packed {
    logic                   rnw;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  localparam int SRAM_REQ_W = $bits(sram_req_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous request FIFO without fall-through; pointers carry an extra wrap bit for full/empty.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage is not reset: an empty FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_req_sequencer.sv
// Queues host requests and replays them one at a time onto the sram_core handshake,
// returning read data (or a timeout error) on a valid/ready response port.
module sram_req_sequencer import sram_pkg::*; #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter bit WRITE_ACK      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rnw,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SRAM_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   core_enable,
  output logic                   core_rnw,
  output logic [SRAM_ADDR_W-1:0] core_addr,
  output logic [SRAM_DATA_W-1:0] core_wdata,
  input  logic [SRAM_DATA_W-1:0] core_rdata,
  input  logic                   core_ready,
  output logic                   busy
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

  function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] t);
    return (t == TMR_MAX) ? t : t + TMR_W'(1);
  endfunction

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  sram_req_t        req_in;
  sram_req_t        fifo_dout;
  sram_req_t        cmd_q;
  logic [TMR_W-1:0] timer;
  logic             cap_ok;
  logic             cap_to;

  // req_ready is forced low while rst is held so nothing is pushed into a flushing FIFO.
  assign req_ready = !rst && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign req_in    = {req_rnw, req_addr, req_wdata};
  assign rsp_valid = (state == RESP);
  assign busy      = !fifo_empty || (state != IDLE);

  sram_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (req_in),
    .pop   (fifo_pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    cap_ok    = 1'b0;
    cap_to    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A ready arriving on the final timer cycle still completes normally.
        if (core_ready) begin
          cap_ok    = 1'b1;
          state_nxt = (!cmd_q.rnw && !WRITE_ACK) ? IDLE : RESP;
        end else if (timer == TMR_LAST) begin
          cap_to    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
    end else if (fifo_pop) begin
      cmd_q <= fifo_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT) begin
      timer <= tmr_sat_inc(timer);
    end
  end

  // Core pins are launched from the command register so they change only on ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_enable <= 1'b0;
      core_rnw    <= 1'b0;
      core_addr   <= '0;
      core_wdata  <= '0;
    end else if (state == ISSUE) begin
      core_enable <= 1'b1;
      core_rnw    <= cmd_q.rnw;
      core_addr   <= cmd_q.addr;
      core_wdata  <= cmd_q.wdata;
    end else if (cap_ok || cap_to) begin
      core_enable <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (cap_ok) begin
      rsp_rdata <= cmd_q.rnw ? core_rdata : '0;
      rsp_err   <= 1'b0;
    end else if (cap_to) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Bench for sram_req_sequencer: a behavioural SRAM core, a response monitor and an in-order reference model.
module tb_sram_req_sequencer;
  import sram_pkg::*;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 15;
  localparam bit WRITE_ACK      = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [9:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       rsp_err;
  logic       core_enable;
  logic       core_rnw;
  logic [9:0] core_addr;
  logic [3:0] core_wdata;
  logic [3:0] core_rdata;
  logic       core_ready;
  logic       busy;

  always #5 clk = ~clk;

  sram_req_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WRITE_ACK      (WRITE_ACK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rnw     (req_rnw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .core_enable (core_enable),
    .core_rnw    (core_rnw),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_ready  (core_ready),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] core_mem [1024];
  logic [3:0] ref_mem  [1024];
  logic [4:0] exp_q [$];
  logic [4:0] obs_q [$];
  bit         stall    = 1'b0;
  bit         lat_rand = 1'b0;
  int         bp_mode  = 0;
  int         en_cnt   = 0;
  int         cur_lat  = 2;

  assign core_rdata = core_mem[core_addr];

  // Behavioural SRAM core: ready cur_lat cycles after enable unless stalled.
  initial begin
    core_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (core_enable) begin
        en_cnt++;
        if (!stall && en_cnt >= cur_lat && !core_ready) begin
          core_ready = 1'b1;
          if (!core_rnw) core_mem[core_addr] = core_wdata;
        end else begin
          core_ready = 1'b0;
        end
      end else begin
        en_cnt     = 0;
        core_ready = 1'b0;
        cur_lat    = lat_rand ? int'($urandom_range(1, 5)) : 2;
      end
    end
  end

  // Response consumer: 0 = always ready, 1 = hold off, 2 = random.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_rdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1);
  end

  function automatic void expect_req(input logic rnw, input logic [9:0] addr,
                                     input logic [3:0] wdata, input bit timed_out);
    if (timed_out) exp_q.push_back(5'b10000);
    else if (rnw) exp_q.push_back({1'b0, ref_mem[addr]});
    else begin
      ref_mem[addr] = wdata;
      if (WRITE_ACK) exp_q.push_back(5'b00000);
    end
  endfunction

  task automatic push_req(input logic rnw, input logic [9:0] addr, input logic [3:0] wdata,
                          output bit ok);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while ((busy || obs_q.size() < exp_q.size()) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 2000);
  endtask

  task automatic test_reset();
    bit ok;
    logic [4:0] e, o;
    rst = 1'b1;
    req_valid = 1'b1; req_rnw = 1'b1; req_addr = 10'h155; req_wdata = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b need 0", req_ready); end
    total++; if ({core_enable, core_rnw, core_addr, core_wdata} !== 16'h0) begin bad++;
      $display("FAIL rst_core_pins: got en=%b rnw=%b addr=%h wd=%h need all 0", core_enable, core_rnw, core_addr, core_wdata); end
    total++; if ({rsp_valid, rsp_err, rsp_rdata, busy} !== 7'h0) begin bad++;
      $display("FAIL rst_rsp_busy: got vld=%b err=%b rd=%h busy=%b need all 0", rsp_valid, rsp_err, rsp_rdata, busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b need 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_req(1'b1, 10'h155, 4'h0, 1'b0);
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rst_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rst_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_write_read();
    bit ok;
    int n;
    logic [4:0] e, o;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 10'h3A5; req_wdata = 4'hB;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b need 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_req(1'b0, 10'h3A5, 4'hB, 1'b0);
    n = 0;
    while (!core_enable && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n != 2) begin bad++; $display("FAIL wr_enable_latency: got %0d need 2", n); end
    total++; if ({core_rnw, core_addr, core_wdata} !== {1'b0, 10'h3A5, 4'hB}) begin bad++;
      $display("FAIL wr_core_cmd: got rnw=%b addr=%h wd=%h need 0/3a5/b", core_rnw, core_addr, core_wdata); end
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n != 4) begin bad++; $display("FAIL wr_rsp_latency: got %0d need 4", n); end
    push_req(1'b1, 10'h3A5, 4'h0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_push: not accepted"); end
    expect_req(1'b1, 10'h3A5, 4'h0, 1'b0);
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_rd_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL wr_rd_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL wr_rd_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wr_rd_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_fifo_full();
    bit ok, acc_now;
    int n, k;
    logic       rnw_a [5];
    logic [9:0] addr_a [5];
    logic [3:0] wd_a [5];
    logic [4:0] e, o;
    for (int i = 0; i < 5; i++) begin
      rnw_a[i] = 1'($urandom); addr_a[i] = 10'($urandom_range(0, 7)); wd_a[i] = 4'($urandom);
    end
    stall = 1'b1;
    push_req(1'b0, 10'h020, 4'h6, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_first_push: not accepted"); end
    expect_req(1'b0, 10'h020, 4'h6, 1'b0);
    n = 0;
    while (!core_enable && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    k = 0;
    req_valid = 1'b1; req_rnw = rnw_a[0]; req_addr = addr_a[0]; req_wdata = wd_a[0];
    for (int c = 0; c < 8; c++) begin
      acc_now = req_ready && (k < 5);
      @(posedge clk); #1;
      if (acc_now) begin
        expect_req(rnw_a[k], addr_a[k], wd_a[k], 1'b0);
        k++;
        if (k < 5) begin req_rnw = rnw_a[k]; req_addr = addr_a[k]; req_wdata = wd_a[k]; end
        else req_valid = 1'b0;
      end
    end
    total++; if (k != FIFO_DEPTH) begin bad++; $display("FAIL full_accept_count: got %0d need %0d", k, FIFO_DEPTH); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_req_ready: got %b need 0", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b need 1", busy); end
    stall = 1'b0;
    if (k < 5) begin
      n = 0;
      while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
      total++; if (n >= 200) begin bad++; $display("FAIL full_slot_free: req_ready stuck at 0"); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      expect_req(rnw_a[k], addr_a[k], wd_a[k], 1'b0);
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL full_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL full_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL full_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [9:0] z;
    logic [4:0] e, o;
    z = 10'h100 + 10'($urandom_range(0, 15));
    stall = 1'b1;
    push_req(1'b0, z, ~ref_mem[z], ok);
    total++; if (!ok) begin bad++; $display("FAIL to_push_wr: not accepted"); end
    expect_req(1'b0, z, ~ref_mem[z], 1'b1);
    push_req(1'b1, z, 4'h0, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_push_rd: not accepted"); end
    expect_req(1'b1, z, 4'h0, 1'b0);
    n = 0;
    while (!core_enable && n < 20) begin @(posedge clk); #1; n++; end
    n = 0;
    while (core_enable && n < 100) begin n++; @(posedge clk); #1; end
    stall = 1'b0;
    total++; if (n != TIMEOUT_CYCLES) begin bad++; $display("FAIL to_enable_cycles: got %0d need %0d", n, TIMEOUT_CYCLES); end
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 6'b110000) begin bad++;
      $display("FAIL to_rsp: got vld=%b err=%b rd=%h need 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL to_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL to_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL to_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [3:0] d;
    logic       er;
    logic [9:0] a0, a1;
    logic [4:0] e, o;
    a0 = 10'($urandom); a1 = 10'($urandom);
    bp_mode = 1;
    push_req(1'b1, a0, 4'h0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_push0: not accepted"); end
    expect_req(1'b1, a0, 4'h0, 1'b0);
    push_req(1'b1, a1, 4'h0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_push1: not accepted"); end
    expect_req(1'b1, a1, 4'h0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (!rsp_valid) begin bad++; $display("FAIL bp_rsp_valid: got 0 need 1"); end
    d = rsp_rdata; er = rsp_err;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata, core_enable} !== {1'b1, er, d, 1'b0}) begin bad++;
        $display("FAIL bp_hold c%0d: got vld=%b err=%b rd=%h en=%b need 1/%b/%h/0", c, rsp_valid, rsp_err, rsp_rdata, core_enable, er, d); end
    end
    bp_mode = 0;
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL bp_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL bp_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bp_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int n;
    logic [9:0] a;
    logic [4:0] e, o;
    stall = 1'b1;
    push_req(1'b1, 10'h011, 4'h0, ok);
    push_req(1'b0, 10'h012, 4'h3, ok);
    n = 0;
    while (!core_enable && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (core_enable !== 1'b1) begin bad++; $display("FAIL mid_enable_before: got %b need 1", core_enable); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({core_enable, busy, req_ready, rsp_valid} !== 4'b0000) begin bad++;
      $display("FAIL mid_async: got en=%b busy=%b rdy=%b vld=%b need all 0", core_enable, busy, req_ready, rsp_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    #1;
    total++; if ({busy, req_ready} !== 2'b01) begin bad++; $display("FAIL mid_release: got busy=%b rdy=%b need 0/1", busy, req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if ({core_enable, busy} !== 2'b00) begin bad++; $display("FAIL mid_lost c%0d: got en=%b busy=%b need 0/0", c, core_enable, busy); end
    end
    exp_q.delete(); obs_q.delete();
    a = 10'($urandom);
    push_req(1'b1, a, 4'h0, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_push_after: not accepted"); end
    expect_req(1'b1, a, 4'h0, 1'b0);
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL mid_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL mid_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_random();
    bit ok;
    logic       r;
    logic [9:0] a;
    logic [3:0] w;
    logic [4:0] e, o;
    lat_rand = 1'b1;
    bp_mode  = 2;
    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom); a = 10'($urandom_range(0, 15)); w = 4'($urandom);
      push_req(r, a, w, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_push %0d: not accepted", i); end
      else expect_req(r, a, w, 1'b0);
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain: timed out, need idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rand_beat: got none need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rand_beat: got %h need %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rand_extra_beats: got %0d need 0", obs_q.size()); obs_q.delete(); end
    lat_rand = 1'b0;
    bp_mode  = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      core_mem[i] = 4'($urandom);
      ref_mem[i]  = core_mem[i];
    end
    test_reset();
    test_write_read();
    test_fifo_full();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
